// File: rtl/hex_display_ctrl.sv
// Registered multi-digit hex display with byte push, zero blanking and blink.
// Optional blink hardware is enabled by defining HEXDISP_BLINK_EN.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    push,
  input  logic [7:0]              push_byte,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    blink_phase
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [VW-1:0]         shifted;
  logic [NUM_DIGITS-1:0] blink_off;
  logic [NUM_DIGITS-1:0] blank;
  logic [SW-1:0]         segs_d;
  logic                  lead;

  // With only two digits the pushed byte replaces the whole value
  if (NUM_DIGITS > 2) begin : g_shift
    assign shifted = {value[VW-9:0], push_byte};
  end else begin : g_noshift
    assign shifted = push_byte;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_data;
    end else if (push) begin
      value <= shifted;
    end
  end

`ifdef HEXDISP_BLINK_EN
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] blink_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_off = blink_phase ? blink_mask : '0;
`else
  logic unused_mask;

  assign unused_mask = ^blink_mask;
  assign blink_phase = 1'b0;
  assign blink_off   = '0;
`endif

  // Blank from the top down while digits stay zero; digit 0 always shows
  always_comb begin
    lead   = lz_suppress;
    blank  = blink_off;
    segs_d = '1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (value[4*i +: 4] == 4'h0)) begin
        blank[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      segs_d[7*i +: 7] = blank[i] ? 7'h7F : glyph(value[4*i +: 4]);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      segs <= '1;
    end else begin
      segs <= segs_d;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: vector table, corner sequences, random vs model.
// Blink expectations follow HEXDISP_BLINK_EN as defined for the build.
module tb_hex_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] DARK = 7'h7F;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          load;
  logic [23:0]   load_data;
  logic          push;
  logic [7:0]    push_byte;
  logic          lz_suppress;
  logic [5:0]    blink_mask;
  logic [23:0]   value;
  logic [41:0]   segs;
  logic          blink_phase;

  int checks = 0;
  int errors = 0;

  logic [23:0] m_val;
  logic [41:0] m_segs;
  logic        m_phase;
  int          edges;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .clear      (clear),
    .load       (load),
    .load_data  (load_data),
    .push       (push),
    .push_byte  (push_byte),
    .lz_suppress(lz_suppress),
    .blink_mask (blink_mask),
    .value      (value),
    .segs       (segs),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] render(input logic [23:0] v,
                                         input logic lz,
                                         input logic [5:0] mask,
                                         input logic ph);
    logic [41:0] r;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      int upper;
      int nib;
      bit blank;
      upper = int'(v) >> (4 * i);
      nib   = upper % 16;
      blank = (lz && i > 0 && upper == 0) || (ph && mask[i]);
      r[7*i +: 7] = blank ? DARK : GLYPH[nib];
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_val   = '0;
    m_segs  = '1;
    m_phase = 1'b0;
    edges   = 0;
  endtask

  task automatic idle_inputs();
    clear     = 1'b0;
    load      = 1'b0;
    push      = 1'b0;
    load_data = '0;
    push_byte = '0;
  endtask

  task automatic step();
    @(posedge clk);
    m_segs = render(m_val, lz_suppress, blink_mask, m_phase);
    if (clear)     m_val = '0;
    else if (load) m_val = load_data;
    else if (push) m_val = {m_val[15:0], push_byte};
    edges++;
`ifdef HEXDISP_BLINK_EN
    m_phase = ((edges / BD) % 2) == 1;
`else
    m_phase = 1'b0;
`endif
    #1;
    check("value", 64'(value), 64'(m_val));
    check("segs", 64'(segs), 64'(m_segs));
    check("blink_phase", 64'(blink_phase), 64'(m_phase));
  endtask

  typedef struct {
    string       name;
    logic        clr;
    logic        ld;
    logic        psh;
    logic [23:0] data;
    logic [7:0]  pb;
    logic [23:0] expv;
    logic        chk_segs;
    logic [41:0] exps;
  } vec_t;

  vec_t vecs [9];
  int   toggles;
  logic last_ph;

  initial begin
    vecs[0] = '{"clr",        1, 0, 0, 24'h0,      8'h00, 24'h000000, 0, '0};
    vecs[1] = '{"push_1c",    0, 0, 1, 24'h0,      8'h1C, 24'h00001C, 0, '0};
    vecs[2] = '{"push_f0",    0, 0, 1, 24'h0,      8'hF0, 24'h001CF0, 0, '0};
    vecs[3] = '{"clr_ld_psh", 1, 1, 1, 24'h123456, 8'hAA, 24'h000000, 1,
                {DARK, DARK, GLYPH[1], GLYPH[12], GLYPH[15], GLYPH[0]}};
    vecs[4] = '{"ld_psh",     0, 1, 1, 24'h000055, 8'h77, 24'h000055, 0, '0};
    vecs[5] = '{"push_ab",    0, 0, 1, 24'h0,      8'hAB, 24'h0055AB, 0, '0};
    vecs[6] = '{"ld_100",     0, 1, 0, 24'h000100, 8'h00, 24'h000100, 0, '0};
    vecs[7] = '{"clr_again",  1, 0, 0, 24'h0,      8'h00, 24'h000000, 1,
                {DARK, DARK, DARK, GLYPH[1], GLYPH[0], GLYPH[0]}};
    vecs[8] = '{"idle_zero",  0, 0, 0, 24'h0,      8'h00, 24'h000000, 1,
                {DARK, DARK, DARK, DARK, DARK, GLYPH[0]}};

    reset       = 1'b1;
    lz_suppress = 1'b0;
    blink_mask  = '0;
    idle_inputs();
    #12;
    check("rst_value", 64'(value), 64'h0);
    check("rst_segs", 64'(segs), 64'(42'h3FF_FFFF_FFFF));
    check("rst_phase", 64'(blink_phase), 64'h0);
    reset = 1'b0;
    model_reset();

    // load a mixed-glyph value
    load      = 1'b1;
    load_data = 24'h12AB3F;
    step();
    idle_inputs();
    step();
    check("load_glyphs", 64'(segs),
          64'({GLYPH[1], GLYPH[2], GLYPH[10], GLYPH[11], GLYPH[3], GLYPH[15]}));

    // strobe priority, pushes and zero blanking
    lz_suppress = 1'b1;
    for (int i = 0; i < 9; i++) begin
      clear     = vecs[i].clr;
      load      = vecs[i].ld;
      push      = vecs[i].psh;
      load_data = vecs[i].data;
      push_byte = vecs[i].pb;
      step();
      check({"tbl_value_", vecs[i].name}, 64'(value), 64'(vecs[i].expv));
      if (vecs[i].chk_segs)
        check({"tbl_segs_", vecs[i].name}, 64'(segs), 64'(vecs[i].exps));
    end
    idle_inputs();

    // blink on digit 0 only
    lz_suppress = 1'b0;
    blink_mask  = 6'b000001;
    load        = 1'b1;
    load_data   = 24'h000007;
    step();
    idle_inputs();
    toggles = 0;
    last_ph = blink_phase;
    for (int i = 0; i < 16; i++) begin
      step();
      if (blink_phase != last_ph) toggles++;
      last_ph = blink_phase;
    end
`ifdef HEXDISP_BLINK_EN
    check("blink_toggles", 64'(toggles), 64'd4);
`else
    check("blink_toggles", 64'(toggles), 64'd0);
`endif
    blink_mask = '0;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      clear       = ($urandom_range(0, 15) == 0);
      load        = ($urandom_range(0, 3) == 0);
      push        = ($urandom_range(0, 2) == 0);
      load_data   = 24'($urandom) >> (4 * $urandom_range(0, 6));
      push_byte   = 8'($urandom);
      lz_suppress = 1'($urandom_range(0, 1));
      blink_mask  = 6'($urandom);
      step();
    end
    idle_inputs();
    lz_suppress = 1'b0;
    blink_mask  = '0;

    // asynchronous reset between edges
    load      = 1'b1;
    load_data = 24'hFFFFFF;
    step();
    idle_inputs();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_value", 64'(value), 64'h0);
    check("async_segs", 64'(segs), 64'(42'h3FF_FFFF_FFFF));
    check("async_phase", 64'(blink_phase), 64'h0);
    #2;
    reset = 1'b0;
    model_reset();
    step();
    check("post_rst_segs", 64'(segs),
          64'({GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0]}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised, registered successor to the combinational single-digit hex decoder. Holds an NUM_DIGITS-nibble display value that is either parallel-loaded or byte-shifted, so PS/2 scan codes scroll across the displays as history. Drives NUM_DIGITS active-low 7-segment digits with leading-zero suppression and per-digit blinking. Sits between the PS/2 receiver and the HEX0..HEXn pins in the demo top level.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 2..8.
BLINK_DIV, 25000000, clock cycles per blink half-period; must be >= 2.

Ports:
CLOCK_50  in  1  system clock; all state is updated on the rising edge.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous clear of the value register.
load  in  1  parallel-load strobe.
load_data  in  4*NUM_DIGITS  value to load; nibble i maps to digit i, digit 0 is rightmost.
push  in  1  byte-push strobe, e.g. a scan-code-valid pulse.
push_byte  in  8  byte shifted into digits 1:0.
lz_suppress  in  1  enables leading-zero blanking.
blink_mask  in  NUM_DIGITS  bit i set: digit i blinks.
value  out  4*NUM_DIGITS  current value register.
segs  out  7*NUM_DIGITS  active-low segments; digit i is at bits [7i+6:7i], bit order g..a.
blink_phase  out  1  current blink phase; 1 means blinking digits are off.

Behaviour:
- Clock is CLOCK_50. Reset is asynchronous and active-high, port name reset.
- Reset values:
  - value = 0.
  - segs = all ones, i.e. every digit dark.
  - blink_phase = 0.
  - Blink counter = 0.
- Value register priority per cycle: clear > load > push.
  - clear: value <= 0.
  - load: value <= load_data.
  - push: value <= {value[4*NUM_DIGITS-9:0], push_byte}. Upper two digits are discarded.
  - Simultaneous strobes: only the highest-priority strobe takes effect; the lower ones are dropped, not queued.
- Latency:
  - A strobe sampled at edge n updates value at edge n.
  - segs reflects the new value at edge n+1. segs is registered from value, lz_suppress, blink_mask and blink_phase.
  - Changes on lz_suppress or blink_mask likewise appear on segs one cycle later.
- Decode table, standard hex glyphs, active-low {g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression, when lz_suppress=1:
  - Scanning from digit NUM_DIGITS-1 downward, each 0 nibble is blanked (7'h7F) until the first nonzero nibble.
  - Digit 0 is never blanked by suppression, so value 0 displays a single "0".
  - Interior zeros are never blanked.
- Blink:
  - The counter counts 0..BLINK_DIV-1. On the cycle it equals BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - While blink_phase=1, every digit with blink_mask[i]=1 outputs 7'h7F.
  - Blanking from blink and from suppression combine as OR.
  - Counter and phase free-run and are not affected by clear, load or push.
- Reset asserted mid-operation forces all reset values immediately, independent of the clock. The first edge after reset deassertion registers decoded segs for value 0.

Optional Feature:
HEXDISP_BLINK_EN.
- Defined: blink counter, blink_phase and blink_mask behave as specified above.
- Undefined:
  - Counter and phase register are not built.
  - blink_phase is tied to 0.
  - blink_mask is ignored; no digit ever blinks.
  - Everything else is unchanged.

Test Plan:
1. Reset, then load=1 with load_data=24'h12AB3F (NUM_DIGITS=6) -> one cycle later value=12AB3F and segs digits 5..0 = 1111001, 0100100, 0001000, 0000011, 0110000, 0001110.
2. From value 0, push 8'h1C, then push 8'hF0 -> value=00001C, then 001CF0. With lz_suppress=1, digits 5..4 are 7'h7F and digits 3..0 show 1, C, F, 0.
3. Same cycle clear=1, load=1, push=1 -> value=0. Next cycle load=1 and push=1 with load_data=24'h000055 -> value=000055 and push_byte is dropped.
4. lz_suppress=1 with value=0 -> digit 0 = 1000000 and digits 5..1 = 7'h7F. With value=000100 -> digits 2..0 show 1, 0, 0.
5. BLINK_DIV=4, blink_mask=6'b000001, value=000007, HEXDISP_BLINK_EN defined -> blink_phase toggles every 4 cycles. Digit 0 alternates 1111000 and 1111111 one cycle after each toggle; other digits are unaffected.
6. Assert reset asynchronously between edges while value=FFFFFF -> value=0, segs all ones and blink_phase=0 immediately. First edge after release shows "0" glyphs on all digits, since lz_suppress=0.
